// File: rtl/ucode_seq_cu_if.sv
// Handshake, microcode-load and control-word bundle between a sequencer
// client (master) and ucode_seq_cu (slave).
interface ucode_seq_cu_if #(
  parameter int CW = 15,
  parameter int AW = 3,
  parameter int RW = 4
);
  logic          go;
  logic          abort;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [CW-1:0] ld_data;
  logic [AW-1:0] n_steps;
  logic [RW-1:0] n_rep;
  logic [CW-1:0] ctrl;
  logic [AW-1:0] CS;
  logic          busy;
  logic          done;

  modport master (
    output go, abort, ld_en, ld_addr, ld_data, n_steps, n_rep,
    input  ctrl, CS, busy, done
  );

  modport slave (
    input  go, abort, ld_en, ld_addr, ld_data, n_steps, n_rep,
    output ctrl, CS, busy, done
  );
endinterface

// File: rtl/ucode_seq_cu.sv
// Microcoded control unit: steps a loadable control-word store on go, repeats
// the body n_rep extra times, pulses done. Optional abort: UCODE_SEQ_ABORT_EN.
module ucode_seq_cu #(
  parameter int CW    = 15,
  parameter int DEPTH = 8,
  parameter int RW    = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  ucode_seq_cu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cs, cs_nxt;
  logic [AW-1:0] last, last_nxt;
  logic [RW-1:0] rep, rep_nxt;
  logic [CW-1:0] mem [DEPTH];
  logic          abort_hit;

`ifdef UCODE_SEQ_ABORT_EN
  assign abort_hit = bus.abort && (state == S_RUN);
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cs    <= '0;
      last  <= AW'(1);
      rep   <= '0;
    end else begin
      state <= state_nxt;
      cs    <= cs_nxt;
      last  <= last_nxt;
      rep   <= rep_nxt;
    end
  end

  // Writes only land while idle so a running program is never disturbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == S_IDLE && bus.ld_en) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_comb begin
    state_nxt = state;
    cs_nxt    = cs;
    last_nxt  = last;
    rep_nxt   = rep;
    case (state)
      S_IDLE: begin
        if (bus.go) begin
          last_nxt  = (bus.n_steps == '0) ? AW'(1) : bus.n_steps;
          rep_nxt   = bus.n_rep;
          cs_nxt    = AW'(1);
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_hit) begin
          state_nxt = S_IDLE;
          cs_nxt    = '0;
          rep_nxt   = '0;
        end else if (cs < last) begin
          cs_nxt = cs + AW'(1);
        end else if (rep != '0) begin
          cs_nxt  = AW'(1);
          rep_nxt = rep - RW'(1);
        end else begin
          state_nxt = S_DONE;
          cs_nxt    = '0;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // CS is 0 whenever idle, so ctrl shows the idle/load word there.
  assign bus.ctrl = (state == S_DONE) ? '0 : mem[cs];
  assign bus.CS   = cs;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_ucode_seq_cu.sv
// Scoreboard bench for ucode_seq_cu: a memory model predicts ctrl/CS/busy/done
// per cycle; expectations are queued at go and popped on each falling edge.
module tb_ucode_seq_cu;

  typedef struct packed {
    logic [14:0] ctrl;
    logic [2:0]  cs;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [14:0] mdl [8];

  ucode_seq_cu_if #(.CW(15), .AW(3), .RW(4)) bus ();

  ucode_seq_cu #(.CW(15), .DEPTH(8), .RW(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t obs();
    exp_t o;
    o.ctrl = bus.ctrl;
    o.cs   = bus.CS;
    o.busy = bus.busy;
    o.done = bus.done;
    return o;
  endfunction

  function automatic exp_t mk(input logic [14:0] c, input int s, input logic b, input logic d);
    exp_t e;
    e.ctrl = c;
    e.cs   = 3'(s);
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  task automatic push_run(input int ns, input int nr);
    int l;
    l = (ns == 0) ? 1 : ns;
    for (int p = 0; p <= nr; p++)
      for (int s = 1; s <= l; s++) q.push_back(mk(mdl[s], s, 1'b1, 1'b0));
    q.push_back(mk(15'h0, 0, 1'b1, 1'b1));
    q.push_back(mk(mdl[0], 0, 1'b0, 1'b0));
  endtask

  task automatic start(input int ns, input int nr);
    bus.n_steps = 3'(ns);
    bus.n_rep   = 4'(nr);
    bus.go      = 1'b1;
    push_run(ns, nr);
  endtask

  task automatic load(input int addr, input logic [14:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'(addr);
    bus.ld_data = data;
    mdl[addr]   = data;
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    repeat (2) @(negedge clk);
    o = obs();
    n_cmp++;
    if (o !== mk(15'h0, 0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", o, mk(15'h0, 0, 1'b0, 1'b0));
    end
    rst = 1'b0;
    @(negedge clk);
    o = obs();
    n_cmp++;
    if (o !== mk(15'h0, 0, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_released: got %h want %h", o, mk(15'h0, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_basic();
    exp_t o, e;
    load(1, 15'h1B00);
    load(2, 15'h1B0A);
    load(3, 15'h1994);
    load(0, 15'h6180);
    n_cmp++;
    if (bus.ctrl !== 15'h6180) begin
      n_fail++;
      $display("FAIL load_visible: got ctrl=%h want 6180", bus.ctrl);
    end
    start(3, 0);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic_run: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_repeat();
    exp_t o, e;
    start(2, 2);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL repeat_run: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_nsteps0();
    exp_t o, e;
    start(0, 0);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL nsteps0_run: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_ld_in_run();
    exp_t o, e;
    int k;
    start(2, 0);
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ld_during_run: got %h want %h", o, e);
      end
      bus.ld_en   = (k == 0);
      bus.ld_addr = 3'd1;
      bus.ld_data = 15'h7FFF;
      k++;
    end
    bus.ld_en = 1'b0;
    start(1, 0);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ld_ignored_check: got %h want %h", o, e);
      end
    end
    bus.ld_en   = 1'b1;
    bus.ld_addr = 3'd1;
    bus.ld_data = 15'h7FFF;
    mdl[1]      = 15'h7FFF;
    start(1, 0);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go    = 1'b0;
      bus.ld_en = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL ld_with_go: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_rst_midrun();
    exp_t o, e;
    start(3, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rst_pre_step: got %h want %h", o, e);
      end
    end
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < 8; i++) mdl[i] = 15'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      o = obs();
      n_cmp++;
      if (o !== mk(15'h0, 0, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL rst_after: got %h want %h", o, mk(15'h0, 0, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
    load(1, 15'h0123);
    load(2, 15'h4567);
    load(0, 15'h0A0A);
    start(2, 0);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rst_new_prog: got %h want %h", o, e);
      end
    end
  endtask

  task automatic test_abort();
    exp_t o, e;
    int k;
    load(3, 15'h1111);
    load(4, 15'h2222);
    load(5, 15'h3333);
    bus.n_steps = 3'd5;
    bus.n_rep   = 4'd0;
    bus.go      = 1'b1;
`ifdef UCODE_SEQ_ABORT_EN
    q.push_back(mk(mdl[1], 1, 1'b1, 1'b0));
    q.push_back(mk(mdl[2], 2, 1'b1, 1'b0));
    q.push_back(mk(mdl[0], 0, 1'b0, 1'b0));
    q.push_back(mk(mdl[0], 0, 1'b0, 1'b0));
`else
    push_run(5, 0);
`endif
    k = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_run: got %h want %h", o, e);
      end
      k++;
      bus.abort = (k == 2);
    end
    bus.abort = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    start(1, 0);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_first: got %h want %h", o, e);
      end
    end
    start(2, 1);
    while (q.size() > 0) begin
      @(negedge clk);
      bus.go = 1'b0;
      e = q.pop_front();
      o = obs();
      n_cmp++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL b2b_second: got %h want %h", o, e);
      end
    end
  endtask

  initial begin
    bus.go      = 1'b0;
    bus.abort   = 1'b0;
    bus.ld_en   = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    bus.n_steps = '0;
    bus.n_rep   = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 15'h0;
    test_reset();
    test_basic();
    test_repeat();
    test_nsteps0();
    test_ld_in_run();
    test_rst_midrun();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
